if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage feeding the ID stage: PC register, next-PC select, internal
//  instruction ROM and the IF/ID pipeline register. Consumes the ID-stage hazard/control
//  outputs (PC_WriteEnable, IFID_WriteEnable, IFID_Flush, Jump, JumpDest) and the
//  later-stage branch resolution; produces Instruction and PC+4 for the ID stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_DEPTH 1024           instruction ROM depth in 32-bit words (power of two)
//  INIT_FILE  "imem.hex"     $readmemh image loaded into ROM at elaboration
// PORTS
//  Clock             in   1   single clock, all state on rising edge
//  Reset             in   1   synchronous, active-high
//  PC_WriteEnable    in   1   1 = PC may update; 0 = hold PC (load-use stall)
//  IFID_WriteEnable  in   1   1 = IF/ID register may load; 0 = hold
//  IFID_Flush        in   1   1 = squash IF/ID contents (jump taken in ID)
//  Jump              in   1   jump decoded in ID; select JumpDest
//  JumpDest          in   32  jump/jr target from ID
//  BranchTaken       in   1   branch resolved taken downstream
//  BranchTarget      in   32  branch target address
//  Instruction       out  32  IF/ID registered instruction to ID
//  PC_Out            out  32  IF/ID registered PC+4 of that instruction
//  IF_PC             out  32  current fetch PC (debug/trace)
// BEHAVIOUR
//  - Reset (sync): PC<=RESET_PC; Instruction<=0 (NOP); PC_Out<=0. Reset overrides all.
//  - ROM read combinational: word = ROM[PC[log2(IMEM_DEPTH)+1:2]]; upper PC bits ignored
//    (address aliases/wraps); PC[1:0] ignored.
//  - Next PC priority: BranchTaken -> BranchTarget; else Jump -> JumpDest; else PC+4.
//    Targets loaded with bits [1:0] forced to 0. PC+4 is modulo 2^32 (FFFF_FFFC -> 0).
//  - PC register: loads next PC when PC_WriteEnable=1. Exception: BranchTaken=1 loads
//    BranchTarget even when PC_WriteEnable=0 (redirect beats stall).
//  - IF/ID register, priority per edge:
//      1. BranchTaken or IFID_Flush -> Instruction<=0, PC_Out<=0 (flush beats stall)
//      2. IFID_WriteEnable=0        -> hold both
//      3. else                       -> Instruction<=ROM word, PC_Out<=PC+4
//  - Latency: instruction at PC appears on Instruction one cycle after PC presented.
//  - Taken jump costs 1 bubble; taken branch squashes IF/ID only (later-stage squash
//    is owned by downstream stages).
//  - Simultaneous Jump+BranchTaken: branch wins (older instruction).
//  - Reset mid-stall or mid-flush: reset values win; no state survives.
// CONFIGURATION
//  IF_PERF_COUNTERS_EN defined: adds outputs FetchCount[31:0], StallCount[31:0].
//   FetchCount +1 each cycle IF/ID loads a non-flushed word; StallCount +1 each cycle
//   PC_WriteEnable=0 and BranchTaken=0. Both cleared on Reset, wrap at 2^32.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset, RESET_PC=0, ROM[0..2]=A,B,C, no control -> Instruction A,B,C on cycles 1,2,3;
//     PC_Out 4,8,C.
//  2. PC_WriteEnable=0,IFID_WriteEnable=0 for 2 cycles at PC=8 -> IF_PC stays 8, IF/ID
//     holds; release -> fetch resumes at 8 with no instruction lost or duplicated.
//  3. Jump=1,JumpDest=0x40,IFID_Flush=1 at PC=0x10 -> next cycle IF_PC=0x40, Instruction=0;
//     following cycle Instruction=ROM[0x10].
//  4. BranchTaken=1,BranchTarget=0x23 with PC_WriteEnable=0 and Jump=1 -> IF_PC=0x20,
//     Instruction=0.
//  5. PC=FFFF_FFFC, no control -> next IF_PC=0, PC_Out=0 captured; assert Reset during
//     stall -> IF_PC=RESET_PC, Instruction=0.
//  6. IF_PERF_COUNTERS_EN: 10 cycles with 3 stall and 1 flush cycle -> StallCount=3,
//     FetchCount=6.

Source files
------------

// File: rtl/if_stage_if.sv
// Bundle of the ID-stage control inputs and IF/ID outputs of the fetch stage.
// The slave modport is the fetch stage; the master modport is the ID/driver side.
interface if_stage_if;
  logic        PC_WriteEnable;
  logic        IFID_WriteEnable;
  logic        IFID_Flush;
  logic        Jump;
  logic [31:0] JumpDest;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction;
  logic [31:0] PC_Out;
  logic [31:0] IF_PC;

  modport master (
    output PC_WriteEnable, IFID_WriteEnable, IFID_Flush, Jump, JumpDest,
           BranchTaken, BranchTarget,
    input  Instruction, PC_Out, IF_PC
  );

  modport slave (
    input  PC_WriteEnable, IFID_WriteEnable, IFID_Flush, Jump, JumpDest,
           BranchTaken, BranchTarget,
    output Instruction, PC_Out, IF_PC
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, ROM and IF/ID register.
// Optional IF_PERF_COUNTERS_EN adds FetchCount/StallCount; ROM image comes from IMEM_INIT.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] IMEM_INIT [IMEM_DEPTH] = '{default: 32'h0}
) (
  input  logic        Clock,
  input  logic        Reset,
  if_stage_if.slave   bus
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcout_q, pcout_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] rom_word;
  logic        squash;

  assign pc_plus4 = pc_q + 32'd4;
  assign rom_word = IMEM_INIT[pc_q[AW+1:2]];
  assign squash   = bus.BranchTaken | bus.IFID_Flush;

  // Branch resolves an older instruction than the jump in ID, so it wins.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.BranchTaken)
      next_pc = {bus.BranchTarget[31:2], 2'b00};
    else if (bus.Jump)
      next_pc = {bus.JumpDest[31:2], 2'b00};
  end

  // A taken branch redirects even through a load-use stall.
  always_comb begin
    pc_d = pc_q;
    if (bus.PC_WriteEnable || bus.BranchTaken)
      pc_d = next_pc;
  end

  always_comb begin
    instr_d = instr_q;
    pcout_d = pcout_q;
    if (squash) begin
      instr_d = 32'h0;
      pcout_d = 32'h0;
    end else if (bus.IFID_WriteEnable) begin
      instr_d = rom_word;
      pcout_d = pc_plus4;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcout_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
    end
  end

  assign bus.Instruction = instr_q;
  assign bus.PC_Out      = pcout_q;
  assign bus.IF_PC       = pc_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!squash && bus.IFID_WriteEnable)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (!bus.PC_WriteEnable && !bus.BranchTaken)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

  // Target low bits are forced to zero and never read.
  logic unused_target_bits;
  assign unused_target_bits = ^{bus.JumpDest[1:0], bus.BranchTarget[1:0]};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, jump, branch, wrap, reset, counters.
module tb_if_stage;
  localparam int DEPTH = 32;
  localparam logic [31:0] ROM_IMG [DEPTH] = '{
    32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
    32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007,
    32'hC0DE_0008, 32'hC0DE_0009, 32'hC0DE_000A, 32'hC0DE_000B,
    32'hC0DE_000C, 32'hC0DE_000D, 32'hC0DE_000E, 32'hC0DE_000F,
    32'hC0DE_0010, 32'hC0DE_0011, 32'hC0DE_0012, 32'hC0DE_0013,
    32'hC0DE_0014, 32'hC0DE_0015, 32'hC0DE_0016, 32'hC0DE_0017,
    32'hC0DE_0018, 32'hC0DE_0019, 32'hC0DE_001A, 32'hC0DE_001B,
    32'hC0DE_001C, 32'hC0DE_001D, 32'hC0DE_001E, 32'hC0DE_001F
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus();

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  if_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .IMEM_INIT(ROM_IMG)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .FetchCount(fetch_cnt),
    .StallCount(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    bus.PC_WriteEnable   = 1'b1;
    bus.IFID_WriteEnable = 1'b1;
    bus.IFID_Flush       = 1'b0;
    bus.Jump             = 1'b0;
    bus.JumpDest         = 32'h0;
    bus.BranchTaken      = 1'b0;
    bus.BranchTarget     = 32'h0;
  endtask

  task automatic test_reset();
    idle_ctrl();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.IF_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.IF_PC, 32'h0); end
    checks++; if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", bus.Instruction, 32'h0); end
    checks++; if (bus.PC_Out !== 32'h0) begin errors++; $display("FAIL reset_pcout got %h want %h", bus.PC_Out, 32'h0); end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.Instruction !== (32'hC0DE_0000 + i)) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, bus.Instruction, 32'hC0DE_0000 + i); end
      checks++; if (bus.PC_Out !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pcout[%0d] got %h want %h", i, bus.PC_Out, 4 * (i + 1)); end
    end
    checks++; if (bus.IF_PC !== 32'hC) begin errors++; $display("FAIL seq_pc got %h want %h", bus.IF_PC, 32'hC); end
  endtask

  task automatic test_stall();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    bus.PC_WriteEnable = 1'b0; bus.IFID_WriteEnable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.IF_PC !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, bus.IF_PC, 32'h8); end
      checks++; if (bus.Instruction !== 32'hC0DE_0001) begin errors++; $display("FAIL stall_instr[%0d] got %h want %h", i, bus.Instruction, 32'hC0DE_0001); end
      checks++; if (bus.PC_Out !== 32'h8) begin errors++; $display("FAIL stall_pcout[%0d] got %h want %h", i, bus.PC_Out, 32'h8); end
    end
    idle_ctrl();
    step();
    checks++; if (bus.Instruction !== 32'hC0DE_0002) begin errors++; $display("FAIL stall_resume_instr got %h want %h", bus.Instruction, 32'hC0DE_0002); end
    checks++; if (bus.PC_Out !== 32'hC) begin errors++; $display("FAIL stall_resume_pcout got %h want %h", bus.PC_Out, 32'hC); end
    checks++; if (bus.IF_PC !== 32'hC) begin errors++; $display("FAIL stall_resume_pc got %h want %h", bus.IF_PC, 32'hC); end
  endtask

  task automatic test_jump();
    step();
    checks++; if (bus.IF_PC !== 32'h10) begin errors++; $display("FAIL jump_pre_pc got %h want %h", bus.IF_PC, 32'h10); end
    bus.Jump = 1'b1; bus.JumpDest = 32'h40; bus.IFID_Flush = 1'b1;
    step();
    checks++; if (bus.IF_PC !== 32'h40) begin errors++; $display("FAIL jump_pc got %h want %h", bus.IF_PC, 32'h40); end
    checks++; if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL jump_bubble got %h want %h", bus.Instruction, 32'h0); end
    idle_ctrl();
    step();
    checks++; if (bus.Instruction !== 32'hC0DE_0010) begin errors++; $display("FAIL jump_target_instr got %h want %h", bus.Instruction, 32'hC0DE_0010); end
    checks++; if (bus.PC_Out !== 32'h44) begin errors++; $display("FAIL jump_target_pcout got %h want %h", bus.PC_Out, 32'h44); end
  endtask

  task automatic test_branch();
    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h23;
    bus.PC_WriteEnable = 1'b0; bus.Jump = 1'b1; bus.JumpDest = 32'h80;
    step();
    checks++; if (bus.IF_PC !== 32'h20) begin errors++; $display("FAIL branch_pc got %h want %h", bus.IF_PC, 32'h20); end
    checks++; if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL branch_squash got %h want %h", bus.Instruction, 32'h0); end
    checks++; if (bus.PC_Out !== 32'h0) begin errors++; $display("FAIL branch_pcout got %h want %h", bus.PC_Out, 32'h0); end
    idle_ctrl();
    step();
    checks++; if (bus.Instruction !== 32'hC0DE_0008) begin errors++; $display("FAIL branch_target_instr got %h want %h", bus.Instruction, 32'hC0DE_0008); end
    checks++; if (bus.PC_Out !== 32'h24) begin errors++; $display("FAIL branch_target_pcout got %h want %h", bus.PC_Out, 32'h24); end
  endtask

  task automatic test_wrap_and_reset();
    bus.Jump = 1'b1; bus.JumpDest = 32'hFFFF_FFFF;
    step();
    checks++; if (bus.IF_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc got %h want %h", bus.IF_PC, 32'hFFFF_FFFC); end
    idle_ctrl();
    step();
    checks++; if (bus.IF_PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", bus.IF_PC, 32'h0); end
    checks++; if (bus.PC_Out !== 32'h0) begin errors++; $display("FAIL wrap_pcout got %h want %h", bus.PC_Out, 32'h0); end
    checks++; if (bus.Instruction !== 32'hC0DE_001F) begin errors++; $display("FAIL wrap_alias_instr got %h want %h", bus.Instruction, 32'hC0DE_001F); end
    step();
    bus.PC_WriteEnable = 1'b0; bus.IFID_WriteEnable = 1'b0;
    step();
    checks++; if (bus.IF_PC !== 32'h4) begin errors++; $display("FAIL wrap_stall_pc got %h want %h", bus.IF_PC, 32'h4); end
    checks++; if (bus.Instruction !== 32'hC0DE_0000) begin errors++; $display("FAIL wrap_stall_instr got %h want %h", bus.Instruction, 32'hC0DE_0000); end
    rst = 1'b1; bus.IFID_Flush = 1'b1;
    step();
    checks++; if (bus.IF_PC !== 32'h0) begin errors++; $display("FAIL rst_stall_pc got %h want %h", bus.IF_PC, 32'h0); end
    checks++; if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL rst_stall_instr got %h want %h", bus.Instruction, 32'h0); end
    checks++; if (bus.PC_Out !== 32'h0) begin errors++; $display("FAIL rst_stall_pcout got %h want %h", bus.PC_Out, 32'h0); end
    rst = 1'b0; idle_ctrl();
  endtask

  task automatic test_back_to_back();
    step();
    bus.PC_WriteEnable = 1'b0; bus.IFID_WriteEnable = 1'b0; bus.IFID_Flush = 1'b1;
    step();
    checks++; if (bus.IF_PC !== 32'h4) begin errors++; $display("FAIL flush_stall_pc got %h want %h", bus.IF_PC, 32'h4); end
    checks++; if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL flush_stall_instr got %h want %h", bus.Instruction, 32'h0); end
    idle_ctrl();
    step();
    checks++; if (bus.Instruction !== 32'hC0DE_0001) begin errors++; $display("FAIL flush_resume_instr got %h want %h", bus.Instruction, 32'hC0DE_0001); end
  endtask

`ifdef IF_PERF_COUNTERS_EN
  task automatic test_perf();
    idle_ctrl();
    rst = 1'b1; step();
    checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL perf_rst_fetch got %0d want 0", fetch_cnt); end
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL perf_rst_stall got %0d want 0", stall_cnt); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_ctrl();
      if (i >= 2 && i <= 4) begin bus.PC_WriteEnable = 1'b0; bus.IFID_WriteEnable = 1'b0; end
      if (i == 5) bus.IFID_Flush = 1'b1;
      step();
    end
    idle_ctrl();
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall got %0d want 3", stall_cnt); end
    checks++; if (fetch_cnt !== 32'd6) begin errors++; $display("FAIL perf_fetch got %0d want 6", fetch_cnt); end
  endtask
`endif

  initial begin
    idle_ctrl();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch();
    test_wrap_and_reset();
    test_back_to_back();
`ifdef IF_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
